// File: rtl/mem_rec_pkg.sv
// Shared types and defaults for the byte record/playback controller.
// The terminator character ends a recording and is never stored.
package mem_rec_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam logic [7:0] TERM_CHAR_DEF = 8'd43;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } rec_state_t;

endpackage

// File: rtl/mem_rec_ram.sv
// Simple dual-port byte RAM.
// One write port, plus one read port with a read enable and a registered output (latency 1).
module mem_rec_ram import mem_rec_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Only the output register is reset; the array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= mem[i_raddr];
    end
  end

endmodule

// File: rtl/mem_rec_ctrl.sv
// Record/playback controller: captures an input byte stream into RAM until a terminator or a full buffer,
// then streams the stored bytes back out over valid/ready.
module mem_rec_ctrl import mem_rec_pkg::*; #(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] TERM_CHAR = TERM_CHAR_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_rec,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_start_play,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_rec_busy,
  output logic              o_play_busy,
  output logic [ADDR_W:0]   o_len,
  output logic              o_full,
  output logic              o_done
);

  localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  rec_state_t state, state_next;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   len;
  logic              full;
  logic              done;
  logic              valid;

  logic              rec_byte;
  logic              rec_term;
  logic              rec_last;
  logic              idle_rec;
  logic              idle_play;
  logic              play_first;
  logic              play_xfer;
  logic              play_last;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign rec_byte   = (state == ST_REC) && i_valid && (i_data != TERM_CHAR);
  assign rec_term   = (state == ST_REC) && i_valid && (i_data == TERM_CHAR);
  assign rec_last   = rec_byte && (len == FULL_LEN - LEN_ONE);
  assign idle_rec   = (state == ST_IDLE) && i_start_rec;
  assign idle_play  = (state == ST_IDLE) && !i_start_rec && i_start_play;
  // valid is low in PLAY only during the entry cycle, before the first read has returned.
  assign play_first = (state == ST_PLAY) && !valid;
  assign play_xfer  = (state == ST_PLAY) && valid && i_ready;
  assign play_last  = ({1'b0, rptr} == len - LEN_ONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (i_start_rec) begin
          state_next = ST_REC;
        end else if (i_start_play && (len != '0)) begin
          state_next = ST_PLAY;
        end
      end
      ST_REC: begin
        if (rec_term || rec_last) begin
          state_next = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (play_xfer && play_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // On a transfer, fetch the following byte in the same cycle so that valid never drops mid-stream.
  always_comb begin
    o_rec_busy  = (state == ST_REC);
    o_play_busy = (state == ST_PLAY);
    ram_we      = rec_byte;
    ram_re      = play_first || (play_xfer && !play_last);
    ram_raddr   = play_first ? rptr : rptr + PTR_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      len   <= '0;
      full  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (idle_rec) begin
        wptr <= '0;
        len  <= '0;
        full <= 1'b0;
      end
      if (idle_play) begin
        rptr <= '0;
        if (len == '0) begin
          done <= 1'b1;
        end
      end
      if (rec_byte) begin
        wptr <= wptr + PTR_ONE;
        len  <= len + LEN_ONE;
        if (rec_last) begin
          full <= 1'b1;
          done <= 1'b1;
        end
      end
      if (rec_term) begin
        done <= 1'b1;
      end
      if (play_first) begin
        valid <= 1'b1;
      end
      // rptr tracks the address of the byte currently presented on o_data.
      if (play_xfer) begin
        if (play_last) begin
          valid <= 1'b0;
          done  <= 1'b1;
        end else begin
          rptr <= rptr + PTR_ONE;
        end
      end
    end
  end

  mem_rec_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (ram_we),
    .i_waddr (wptr),
    .i_wdata (i_data),
    .i_re    (ram_re),
    .i_raddr (ram_raddr),
    .o_rdata (ram_rdata)
  );

  assign o_data  = ram_rdata;
  assign o_valid = valid;
  assign o_len   = len;
  assign o_full  = full;
  assign o_done  = done;

endmodule

// File: tb/tb_mem_rec_ctrl.sv
// Bench for mem_rec_ctrl: directed record/playback steps with random data and ready patterns,
// checked against an array model of what the buffer should hold.
module tb_mem_rec_ctrl;

  localparam int         DEPTH = 32;
  localparam logic [7:0] TERM  = 8'd43;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start_rec;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_start_play;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_rec_busy;
  logic       o_play_busy;
  logic [5:0] o_len;
  logic       o_full;
  logic       o_done;

  int checks = 0;
  int failures = 0;
  int doneCount = 0;

  logic [7:0] modelMem [DEPTH];
  int         modelLen = 0;
  logic       modelFull = 1'b0;
  logic [7:0] q [$];

  mem_rec_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start_rec  (i_start_rec),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_start_play (i_start_play),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_rec_busy   (o_rec_busy),
    .o_play_busy  (o_play_busy),
    .o_len        (o_len),
    .o_full       (o_full),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_done === 1'b1) doneCount++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic startRec, input logic startPlay, input logic valid,
                               input logic [7:0] data, input logic ready);
    i_start_rec  = startRec;
    i_start_play = startPlay;
    i_valid      = valid;
    i_data       = data;
    i_ready      = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, o_valid, 0);
    checkOutput({tag, "_rec_busy"}, o_rec_busy, 0);
    checkOutput({tag, "_play_busy"}, o_play_busy, 0);
    checkOutput({tag, "_full"}, o_full, 0);
    checkOutput({tag, "_done"}, o_done, 0);
    checkOutput({tag, "_len"}, o_len, 0);
    checkOutput({tag, "_data"}, o_data, 0);
  endtask

  function automatic logic [7:0] randChar();
    logic [7:0] b;
    b = 8'($urandom_range(32, 126));
    if (b == TERM) b = 8'd44;
    return b;
  endfunction

  // Model: bytes are kept until the terminator or until the buffer holds DEPTH bytes.
  task automatic recordSeq(input logic [7:0] bytes [$], input string tag);
    int  startDone;
    bit  active;
    startDone = doneCount;
    applyStimulus(1, 0, 0, 8'd0, 0);
    tick();
    checkOutput({tag, "_rec_busy"}, o_rec_busy, 1);
    modelLen  = 0;
    modelFull = 1'b0;
    active    = 1'b1;
    foreach (bytes[i]) begin
      applyStimulus(0, 0, 1, bytes[i], 0);
      tick();
      if (active) begin
        if (bytes[i] == TERM) begin
          active = 1'b0;
        end else begin
          modelMem[modelLen] = bytes[i];
          modelLen++;
          if (modelLen == DEPTH) begin
            modelFull = 1'b1;
            active    = 1'b0;
          end
        end
        if (!active) begin
          checkOutput({tag, "_done_pulse"}, o_done, 1);
          checkOutput({tag, "_rec_end"}, o_rec_busy, 0);
        end
      end
    end
    applyStimulus(0, 0, 0, 8'd0, 0);
    tick();
    tick();
    checkOutput({tag, "_len"}, o_len, modelLen);
    checkOutput({tag, "_full"}, o_full, modelFull);
    checkOutput({tag, "_done_count"}, doneCount - startDone, active ? 0 : 1);
  endtask

  // readyMode: 0 = always ready, 1 = pattern 1,0,0,..., 2 = random.
  task automatic playSeq(input int readyMode, input string tag);
    int         startDone;
    int         idx;
    int         cyc;
    bit         holding;
    logic       rdy;
    logic [7:0] heldData;
    startDone = doneCount;
    applyStimulus(0, 1, 0, 8'd0, 1);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 0);
    if (modelLen == 0) begin
      checkOutput({tag, "_empty_done"}, o_done, 1);
      checkOutput({tag, "_empty_valid"}, o_valid, 0);
      checkOutput({tag, "_empty_busy"}, o_play_busy, 0);
      tick();
      checkOutput({tag, "_empty_valid2"}, o_valid, 0);
      checkOutput({tag, "_done_count"}, doneCount - startDone, 1);
      return;
    end
    checkOutput({tag, "_entry_valid"}, o_valid, 0);
    checkOutput({tag, "_entry_busy"}, o_play_busy, 1);
    tick();
    checkOutput({tag, "_first_valid"}, o_valid, 1);
    idx = 0;
    cyc = 0;
    holding = 1'b0;
    heldData = 8'd0;
    while (idx < modelLen && cyc < 500) begin
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      checkOutput({tag, "_valid"}, o_valid, 1);
      if (holding) checkOutput({tag, "_stall_hold"}, o_data, heldData);
      i_ready = rdy;
      if (o_valid === 1'b1 && rdy) begin
        checkOutput({tag, "_data"}, o_data, modelMem[idx]);
        idx++;
        holding = 1'b0;
      end else if (o_valid === 1'b1) begin
        holding  = 1'b1;
        heldData = o_data;
      end
      tick();
      cyc++;
    end
    checkOutput({tag, "_count"}, idx, modelLen);
    if (readyMode == 0) checkOutput({tag, "_cycles"}, cyc, modelLen);
    checkOutput({tag, "_end_valid"}, o_valid, 0);
    checkOutput({tag, "_end_done"}, o_done, 1);
    checkOutput({tag, "_end_busy"}, o_play_busy, 0);
    i_ready = 1'b0;
    tick();
    checkOutput({tag, "_done_count"}, doneCount - startDone, 1);
  endtask

  initial begin
    string name;
    int    savedDone;
    applyStimulus(0, 0, 0, 8'd0, 0);
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    checkResetState("reset");
    checkOutput("reset_done_count", doneCount, 0);

    $display("[TB] playback of empty buffer");
    playSeq(0, "empty");

    $display("[TB] record name string");
    name = "HERASHCHENKO_ARTEM_DK91+";
    q = {};
    for (int i = 0; i < name.len(); i++) q.push_back(name[i]);
    recordSeq(q, "name");
    checkOutput("name_len_abs", o_len, 23);
    checkOutput("name_first_char", modelMem[0], 72);

    $display("[TB] playback variants");
    playSeq(0, "play_ready");
    playSeq(1, "play_toggle");
    playSeq(2, "play_rand");

    $display("[TB] simultaneous start pulses");
    applyStimulus(1, 1, 0, 8'd0, 0);
    tick();
    checkOutput("both_rec_busy", o_rec_busy, 1);
    checkOutput("both_play_busy", o_play_busy, 0);
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(randChar());
    q.push_back(TERM);
    recordSeq(q, "both_rec");
    playSeq(2, "both_play");

    $display("[TB] overflow record");
    q = {};
    for (int i = 0; i < 40; i++) q.push_back(randChar());
    recordSeq(q, "overflow");
    checkOutput("overflow_len_abs", o_len, 32);
    playSeq(2, "overflow_play");

    $display("[TB] reset during record");
    savedDone = doneCount;
    applyStimulus(1, 0, 0, 8'd0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, randChar(), 0);
      tick();
    end
    applyStimulus(0, 1, 1, randChar(), 0);
    tick();
    checkOutput("midrec_play_ignored", o_play_busy, 0);
    checkOutput("midrec_rec_busy", o_rec_busy, 1);
    checkOutput("midrec_len", o_len, 6);
    applyStimulus(0, 0, 0, 8'd0, 0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkResetState("midrec_reset");
    modelLen  = 0;
    modelFull = 1'b0;
    tick();
    checkOutput("midrec_no_done", doneCount - savedDone, 0);

    $display("[TB] reset during playback");
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(randChar());
    q.push_back(TERM);
    recordSeq(q, "midplay_rec");
    savedDone = doneCount;
    applyStimulus(0, 1, 0, 8'd0, 1);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      checkOutput("midplay_data", o_data, modelMem[k]);
      tick();
    end
    applyStimulus(1, 0, 0, 8'd0, 1);
    tick();
    checkOutput("midplay_rec_ignored", o_rec_busy, 0);
    checkOutput("midplay_busy", o_play_busy, 1);
    checkOutput("midplay_data4", o_data, modelMem[4]);
    applyStimulus(0, 0, 0, 8'd0, 0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkResetState("midplay_reset");
    modelLen  = 0;
    modelFull = 1'b0;
    tick();
    checkOutput("midplay_no_done", doneCount - savedDone, 0);
    playSeq(0, "after_reset_play");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
